frog_game_ctrl: RTL and testbench



---
 rtl/frog_game_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_frog_game_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frog_game_ctrl.sv
// Frame-rate sequencer for the crossing game: game FSM, player movement,
// lives/level/score bookkeeping and per-lane car step scheduling.
//
// state | meaning
// ------+-----------------------------------------------------------
// TITLE | idle, waiting for any switch to start a new game
// PLAY  | player moves, lanes step, collisions and goals evaluated
// HIT   | player was hit, sprite blinks for HOLD_FRAMES ticks
// GOAL  | crossing scored, goal position shown for HOLD_FRAMES ticks
// OVER  | no lives left, switches locked out for HOLD_FRAMES ticks
module frog_game_ctrl #(
    parameter int H_DISPLAY        = 640,
    parameter int TILE             = 32,
    parameter int PLAYER_W         = 32,
    parameter int START_X          = 304,
    parameter int START_Y          = 416,
    parameter int GOAL_Y           = 0,
    parameter int MOVE_COOLDOWN    = 8,
    parameter int LIVES_INIT       = 3,
    parameter int NUM_LANES        = 4,
    parameter int LANE_PERIOD_BASE = 30,
    parameter int LEVEL_MAX        = 7,
    parameter int HOLD_FRAMES      = 60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 sw_up,
    input  logic                 sw_down,
    input  logic                 sw_left,
    input  logic                 sw_right,
    input  logic                 collide,
    output logic [9:0]           player_x,
    output logic [9:0]           player_y,
    output logic [NUM_LANES-1:0] lane_step,
    output logic [1:0]           lives,
    output logic [2:0]           level,
    output logic [13:0]          score,
    output logic [2:0]           state,
    output logic                 flash
);

    localparam int CDW = $clog2(MOVE_COOLDOWN + 1);
    localparam int HW  = $clog2(HOLD_FRAMES + 1);
    localparam int LCW = $clog2(LANE_PERIOD_BASE + 1);

    localparam logic [9:0]     TILE_P    = 10'(TILE);
    localparam logic [9:0]     START_X_P = 10'(START_X);
    localparam logic [9:0]     START_Y_P = 10'(START_Y);
    localparam logic [9:0]     GOAL_Y_P  = 10'(GOAL_Y);
    localparam logic [10:0]    TILE_W    = 11'(TILE);
    localparam logic [10:0]    PW_W      = 11'(PLAYER_W);
    localparam logic [10:0]    START_Y_W = 11'(START_Y);
    localparam logic [10:0]    HDISP_W   = 11'(H_DISPLAY);
    localparam logic [CDW-1:0] COOL_P    = CDW'(MOVE_COOLDOWN);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic [HW-1:0]  HOLD_END  = HW'(HOLD_FRAMES);
    localparam logic [1:0]     LIVES_P   = 2'(LIVES_INIT);
    localparam logic [2:0]     LEVEL_TOP = 3'(LEVEL_MAX);
    localparam logic [14:0]    SCORE_MAX = 15'd9999;

    typedef enum logic [2:0] {
        S_TITLE = 3'd0,
        S_PLAY  = 3'd1,
        S_HIT   = 3'd2,
        S_GOAL  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t               state_q, state_n;
    logic [9:0]           x_q, x_n, y_q, y_n;
    logic [1:0]           lives_q, lives_n;
    logic [2:0]           level_q, level_n;
    logic [13:0]          score_q, score_n;
    logic [CDW-1:0]       cool_q, cool_n;
    logic [HW-1:0]        hold_q, hold_n;
    logic                 flash_q, flash_n;
    logic [NUM_LANES-1:0] lane_step_q, lane_step_n;
    logic [LCW-1:0]       lane_cnt_q [NUM_LANES];
    logic [LCW-1:0]       lane_cnt_n [NUM_LANES];

    logic                 any_sw;
    logic                 move_ok;
    logic [9:0]           nx, ny;
    logic [HW-1:0]        hold_inc;
    logic [14:0]          goal_pts;
    logic [14:0]          score_sum;

    // Lane period shrinks with level and with lane index, never below 2 frames.
    function automatic logic [LCW-1:0] lane_period(input logic [2:0] lvl, input int lane);
        int p;
        p = LANE_PERIOD_BASE - 3 * int'(lvl) - 2 * lane;
        if (p < 2) p = 2;
        return LCW'(p);
    endfunction

    assign any_sw    = sw_up | sw_down | sw_left | sw_right;
    assign hold_inc  = hold_q + HW'(1);
    assign goal_pts  = 15'(level_q) * 15'd10 + 15'd10;
    assign score_sum = {1'b0, score_q} + goal_pts;

    // State register and all bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_TITLE;
            x_q         <= START_X_P;
            y_q         <= START_Y_P;
            lives_q     <= LIVES_P;
            level_q     <= '0;
            score_q     <= '0;
            cool_q      <= '0;
            hold_q      <= '0;
            flash_q     <= 1'b0;
            lane_step_q <= '0;
            lane_cnt_q  <= '{default: '0};
        end else begin
            state_q     <= state_n;
            x_q         <= x_n;
            y_q         <= y_n;
            lives_q     <= lives_n;
            level_q     <= level_n;
            score_q     <= score_n;
            cool_q      <= cool_n;
            hold_q      <= hold_n;
            flash_q     <= flash_n;
            lane_step_q <= lane_step_n;
            lane_cnt_q  <= lane_cnt_n;
        end
    end

    // Next-state logic; everything holds except on frame ticks, lane pulses self-clear.
    always_comb begin
        state_n     = state_q;
        x_n         = x_q;
        y_n         = y_q;
        lives_n     = lives_q;
        level_n     = level_q;
        score_n     = score_q;
        cool_n      = cool_q;
        hold_n      = hold_q;
        flash_n     = flash_q;
        lane_step_n = '0;
        for (int i = 0; i < NUM_LANES; i++) lane_cnt_n[i] = lane_cnt_q[i];
        move_ok     = 1'b0;
        nx          = x_q;
        ny          = y_q;

        if (frame_tick) begin
            unique case (state_q)
                S_TITLE: begin
                    if (any_sw) begin
                        state_n = S_PLAY;
                        cool_n  = COOL_P;
                        lives_n = LIVES_P;
                        level_n = '0;
                        score_n = '0;
                        hold_n  = '0;
                        flash_n = 1'b0;
                        x_n     = START_X_P;
                        y_n     = START_Y_P;
                        for (int i = 0; i < NUM_LANES; i++) lane_cnt_n[i] = '0;
                    end
                end

                S_PLAY: begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (lane_cnt_q[i] >= lane_period(level_q, i) - LCW'(1)) begin
                            lane_step_n[i] = 1'b1;
                            lane_cnt_n[i]  = '0;
                        end else begin
                            lane_cnt_n[i] = lane_cnt_q[i] + LCW'(1);
                        end
                    end

                    if (collide) begin
                        x_n    = START_X_P;
                        y_n    = START_Y_P;
                        hold_n = '0;
                        if (lives_q <= 2'd1) begin
                            lives_n = '0;
                            state_n = S_OVER;
                        end else begin
                            lives_n = lives_q - 2'd1;
                            state_n = S_HIT;
                        end
                    end else if (cool_q != '0) begin
                        cool_n = cool_q - CDW'(1);
                    end else begin
                        // Only the highest-priority switch is considered, even if blocked.
                        if (sw_up) begin
                            move_ok = (y_q >= TILE_P);
                            ny      = y_q - TILE_P;
                        end else if (sw_down) begin
                            move_ok = ({1'b0, y_q} + TILE_W <= START_Y_W);
                            ny      = y_q + TILE_P;
                        end else if (sw_left) begin
                            move_ok = (x_q >= TILE_P);
                            nx      = x_q - TILE_P;
                        end else if (sw_right) begin
                            move_ok = ({1'b0, x_q} + TILE_W + PW_W <= HDISP_W);
                            nx      = x_q + TILE_P;
                        end

                        if (move_ok) begin
                            x_n    = nx;
                            y_n    = ny;
                            cool_n = COOL_P;
                            if (ny == GOAL_Y_P) begin
                                state_n = S_GOAL;
                                hold_n  = '0;
                                score_n = (score_sum > SCORE_MAX) ? 14'd9999 : score_sum[13:0];
                                if (level_q < LEVEL_TOP) level_n = level_q + 3'd1;
                            end
                        end
                    end
                end

                S_HIT, S_GOAL: begin
                    if (hold_q == HOLD_LAST) begin
                        state_n = S_PLAY;
                        hold_n  = '0;
                        cool_n  = COOL_P;
                        flash_n = 1'b0;
                        if (state_q == S_GOAL) begin
                            x_n = START_X_P;
                            y_n = START_Y_P;
                        end
                    end else begin
                        hold_n  = hold_inc;
                        flash_n = (state_q == S_HIT) && hold_inc[3];
                    end
                end

                S_OVER: begin
                    if (hold_q >= HOLD_END) begin
                        if (any_sw) begin
                            state_n = S_TITLE;
                            hold_n  = '0;
                        end
                    end else begin
                        hold_n = hold_inc;
                    end
                end

                default: state_n = S_TITLE;
            endcase
        end
    end

    assign player_x  = x_q;
    assign player_y  = y_q;
    assign lane_step = lane_step_q;
    assign lives     = lives_q;
    assign level     = level_q;
    assign score     = score_q;
    assign state     = state_q;
    assign flash     = flash_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl: movement timing, arbitration, boundaries,
// lane schedule, collisions, game over, goals, level saturation and reset.
module tb_frog_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        sw_up, sw_down, sw_left, sw_right;
    logic        collide;
    logic [9:0]  player_x, player_y;
    logic [3:0]  lane_step;
    logic [1:0]  lives;
    logic [2:0]  level;
    logic [13:0] score;
    logic [2:0]  state;
    logic        flash;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int n;
    logic [3:0] exp_ls;

    frog_game_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .sw_up      (sw_up),
        .sw_down    (sw_down),
        .sw_left    (sw_left),
        .sw_right   (sw_right),
        .collide    (collide),
        .player_x   (player_x),
        .player_y   (player_y),
        .lane_step  (lane_step),
        .lives      (lives),
        .level      (level),
        .score      (score),
        .state      (state),
        .flash      (flash)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame tick; returns on the falling edge after the sampling edge.
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_tick = 1'b0;
        {sw_up, sw_down, sw_left, sw_right, collide} = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_x"}, player_x, 304);
        check({tag, "_y"}, player_y, 416);
        check({tag, "_lives"}, lives, 3);
        check({tag, "_level"}, level, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_lane"}, lane_step, 0);
        check({tag, "_flash"}, flash, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        frame_tick = 1'b0;
        {sw_up, sw_down, sw_left, sw_right, collide} = '0;
        #12;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Move cadence with SW_UP held, then the level-0 lane schedule.
        sw_up = 1'b1;
        tick();                       // tick 1
        check("b_play", state, 1);
        repeat (8) tick();            // tick 9
        check("b_y_t9", player_y, 416);
        tick();                       // tick 10
        check("b_y_t10", player_y, 384);
        repeat (8) tick();            // tick 18
        check("b_y_t18", player_y, 384);
        tick();                       // tick 19
        check("b_y_t19", player_y, 352);
        sw_up = 1'b0;
        for (int t = 20; t <= 61; t++) begin
            tick();
            case (t)
                25, 49:  exp_ls = 4'b1000;
                27, 53:  exp_ls = 4'b0100;
                29, 57:  exp_ls = 4'b0010;
                31, 61:  exp_ls = 4'b0001;
                default: exp_ls = 4'b0000;
            endcase
            check($sformatf("b_lane_t%0d", t), lane_step, exp_ls);
        end
        check("b_y_idle", player_y, 352);

        // All four switches: only UP applies.
        do_reset();
        {sw_up, sw_down, sw_left, sw_right} = 4'b1111;
        tick();
        repeat (8) tick();
        check("c_y_t9", player_y, 416);
        tick();
        check("c_y_t10", player_y, 384);
        check("c_x_t10", player_x, 304);
        {sw_up, sw_down, sw_left, sw_right} = 4'b0000;

        // Left edge: blocked move leaves cooldown at 0; then the right edge.
        do_reset();
        sw_left = 1'b1;
        tick();
        repeat (9) tick();            // tick 10
        check("d_x_first", player_x, 272);
        repeat (8) repeat (9) tick(); // tick 82
        check("d_x_t82", player_x, 16);
        repeat (8) tick();            // tick 90
        check("d_x_t90", player_x, 16);
        tick();                       // tick 91, blocked
        check("d_x_blocked", player_x, 16);
        sw_left = 1'b0;
        sw_right = 1'b1;
        tick();                       // tick 92
        check("d_x_right", player_x, 48);
        repeat (17) repeat (9) tick();// tick 245
        check("d_x_t245", player_x, 592);
        repeat (9) tick();            // tick 254, blocked
        check("d_x_rblocked", player_x, 592);
        sw_right = 1'b0;

        // Collisions, HIT blink, game over lockout.
        do_reset();
        sw_up = 1'b1;
        tick();
        check("e_lives_start", lives, 3);
        repeat (9) tick();            // tick 10
        check("e_y_t10", player_y, 384);
        sw_up = 1'b0;
        collide = 1'b1;
        tick();                       // tick 11
        collide = 1'b0;
        check("e_hit_state", state, 2);
        check("e_hit_lives", lives, 2);
        check("e_hit_y", player_y, 416);
        check("e_hit_x", player_x, 304);
        repeat (7) tick();            // tick 18
        check("e_flash_t18", flash, 0);
        tick();                       // tick 19
        check("e_flash_t19", flash, 1);
        repeat (8) tick();            // tick 27
        check("e_flash_t27", flash, 0);
        repeat (43) tick();           // tick 70
        check("e_hit_t70", state, 2);
        tick();                       // tick 71
        check("e_play_t71", state, 1);
        check("e_flash_t71", flash, 0);
        collide = 1'b1;
        tick();                       // tick 72
        collide = 1'b0;
        check("e_hit2_lives", lives, 1);
        repeat (60) tick();           // tick 132
        check("e_play_t132", state, 1);
        collide = 1'b1;
        sw_up = 1'b1;
        tick();                       // tick 133
        collide = 1'b0;
        sw_up = 1'b0;
        check("e_over_state", state, 4);
        check("e_over_lives", lives, 0);
        check("e_over_x", player_x, 304);
        check("e_over_y", player_y, 416);
        sw_down = 1'b1;
        repeat (60) tick();           // tick 193
        check("e_over_locked", state, 4);
        tick();                       // tick 194
        check("e_title", state, 0);
        tick();                       // tick 195
        check("e_restart_state", state, 1);
        check("e_restart_lives", lives, 3);
        sw_down = 1'b0;

        // First crossing, then asynchronous reset in the middle of GOAL.
        do_reset();
        sw_up = 1'b1;
        tick();
        repeat (12) repeat (9) tick();// tick 109
        repeat (8) tick();            // tick 117
        check("f_y_t117", player_y, 32);
        check("f_state_t117", state, 1);
        tick();                       // tick 118
        check("f_goal_y", player_y, 0);
        check("f_goal_state", state, 3);
        check("f_goal_score", score, 10);
        check("f_goal_level", level, 1);
        sw_up = 1'b0;
        tick();
        check("f_goal_hold_y", player_y, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("f_async");
        @(negedge clk);
        rst_n = 1'b1;

        // Seven crossings to level 7, lane periods there, then level saturation.
        do_reset();
        sw_up = 1'b1;
        n = 0;
        while (!(level == 3'd7 && state == 3'd1) && n < 3000) begin
            tick();
            n++;
        end
        check("g_reach_l7", (n < 3000), 1);
        sw_up = 1'b0;
        check("g_level", level, 7);
        check("g_score", score, 280);

        n = 0;
        while (!lane_step[0] && n < 40) begin tick(); n++; end
        check("g_l0_seen", lane_step[0], 1);
        n = 0;
        do begin tick(); n++; end while (!lane_step[0] && n < 40);
        check("g_l0_period", n, 9);

        n = 0;
        while (!lane_step[3] && n < 40) begin tick(); n++; end
        check("g_l3_seen", lane_step[3], 1);
        n = 0;
        do begin tick(); n++; end while (!lane_step[3] && n < 40);
        check("g_l3_period", n, 3);

        sw_up = 1'b1;
        n = 0;
        while (state != 3'd3 && n < 300) begin tick(); n++; end
        check("g_goal8_seen", state, 3);
        check("g_level_sat", level, 7);
        check("g_score8", score, 360);
        sw_up = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
